// File: rtl/bit_count_pkg.sv
// rtl/bit_count_pkg.sv - shared state and mode types for the bit count engine
package bit_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_ONES      = 2'd0,
    MODE_ZEROS     = 2'd1,
    MODE_MATCH_LSB = 2'd2,
    MODE_LZC       = 2'd3
  } mode_t;

endpackage

// File: rtl/bit_chunk_eval.sv
// rtl/bit_chunk_eval.sv - combinational count contribution of one chunk, MSB first
module bit_chunk_eval
  import bit_count_pkg::*;
#(
  parameter  int BITS_PER_CYCLE = 1,
  localparam int CW             = $clog2(BITS_PER_CYCLE + 1)
) (
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  mode_t                     mode,
  input  logic                      ref_lsb,
  input  logic                      seen_one_in,
  output logic [CW-1:0]             chunk_cnt,
  output logic                      seen_one_out
);

  logic seen;
  logic hit;

  always_comb begin
    chunk_cnt = '0;
    seen      = seen_one_in;
    hit       = 1'b0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      case (mode)
        MODE_ONES:      hit = chunk[i];
        MODE_ZEROS:     hit = ~chunk[i];
        MODE_MATCH_LSB: hit = (chunk[i] == ref_lsb);
        default:        hit = ~seen & ~chunk[i];
      endcase
      if (hit) chunk_cnt = chunk_cnt + CW'(1);
      // The leading-zero run ends at the first 1, even mid-chunk.
      if (chunk[i]) seen = 1'b1;
    end
  end

  assign seen_one_out = seen;

endmodule

// File: rtl/bit_count_engine.sv
// rtl/bit_count_engine.sv - serial per-word bit counter with valid/ready handshakes
module bit_count_engine
  import bit_count_pkg::*;
#(
  parameter  int DATA_W         = 8,
  parameter  int BITS_PER_CYCLE = 1,
  localparam int CNT_W          = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [CNT_W-1:0]  data_out,
  output logic [1:0]        mode_out,
  output logic [1:0]        out_state
);

  localparam int STEPS       = DATA_W / BITS_PER_CYCLE;
  localparam int IDX_W       = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CHUNK_CNT_W = $clog2(BITS_PER_CYCLE + 1);

  if (DATA_W < 2 || BITS_PER_CYCLE < 1 || (DATA_W % BITS_PER_CYCLE) != 0) begin : g_param_check
    $error("bit_count_engine: DATA_W must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_t             state;
  mode_t              mode_q;
  logic [DATA_W-1:0]  data_q;
  logic               lsb_q;
  logic               seen_one;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   count;

  logic [CHUNK_CNT_W-1:0] chunk_cnt;
  logic                   seen_one_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic [CNT_W-1:0]       result;

  // data_q shifts left each step, so the chunk under evaluation is always its top slice.
  bit_chunk_eval #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_eval (
    .chunk        (data_q[DATA_W-1 -: BITS_PER_CYCLE]),
    .mode         (mode_q),
    .ref_lsb      (lsb_q),
    .seen_one_in  (seen_one),
    .chunk_cnt    (chunk_cnt),
    .seen_one_out (seen_one_nxt)
  );

  assign count_nxt = count + CNT_W'(chunk_cnt);
  // Bit 0 always matches itself, so it is removed once at the end.
  assign result    = (mode_q == MODE_MATCH_LSB) ? count_nxt - CNT_W'(1) : count_nxt;
  assign out_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      data_out  <= '0;
      mode_out  <= 2'd0;
      mode_q    <= MODE_ONES;
      data_q    <= '0;
      lsb_q     <= 1'b0;
      seen_one  <= 1'b0;
      idx       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_in) begin
            data_q   <= data_in;
            mode_q   <= mode_t'(mode_in);
            lsb_q    <= data_in[0];
            seen_one <= 1'b0;
            count    <= '0;
            idx      <= IDX_W'(STEPS - 1);
            ready_in <= 1'b0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          count    <= count_nxt;
          seen_one <= seen_one_nxt;
          data_q   <= data_q << BITS_PER_CYCLE;
          if (idx == '0) begin
            data_out  <= result;
            mode_out  <= mode_q;
            valid_out <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          valid_out <= 1'b0;
          ready_in  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_count_engine.sv
// tb/tb_bit_count_engine.sv - self-checking bench for bit_count_engine (1 and 4 bits per cycle)
module tb_bit_count_engine;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       vin  [2];
  logic       rdy  [2];
  logic [7:0] din  [2];
  logic [1:0] min  [2];
  logic       vout [2];
  logic       rout [2];
  logic [3:0] dout [2];
  logic [1:0] mout [2];
  logic [1:0] ost  [2];

  bit_count_engine #(.DATA_W(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset),
    .valid_in(vin[0]), .ready_in(rdy[0]), .data_in(din[0]), .mode_in(min[0]),
    .valid_out(vout[0]), .ready_out(rout[0]), .data_out(dout[0]), .mode_out(mout[0]),
    .out_state(ost[0])
  );

  bit_count_engine #(.DATA_W(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset),
    .valid_in(vin[1]), .ready_in(rdy[1]), .data_in(din[1]), .mode_in(min[1]),
    .valid_out(vout[1]), .ready_out(rout[1]), .data_out(dout[1]), .mode_out(mout[1]),
    .out_state(ost[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  function automatic int ref_count(logic [7:0] d, int m);
    int n = 0;
    int i = 7;
    case (m)
      0: n = $countones(d);
      1: n = 8 - $countones(d);
      2: for (int j = 1; j < 8; j++) if (d[j] == d[0]) n++;
      default: while (i >= 0 && d[i] == 1'b0) begin n++; i--; end
    endcase
    return n;
  endfunction

  // Behavioural model: a word occupies the engine for STEPS edges, then waits for the consumer.
  bit m_ready   [2] = '{1'b1, 1'b1};
  bit m_valid   [2] = '{1'b0, 1'b0};
  int m_timer   [2] = '{0, 0};
  int m_pend    [2] = '{0, 0};
  int m_pmode   [2] = '{0, 0};
  int m_res     [2] = '{0, 0};
  int m_mode    [2] = '{0, 0};
  int acc_cyc   [2] = '{0, 0};
  int dut_xfers [2] = '{0, 0};
  int cyc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_ready[k] = 1'b1;
        m_valid[k] = 1'b0;
        m_timer[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (m_ready[k]) begin
          if (vin[k]) begin
            m_ready[k] = 1'b0;
            m_timer[k] = (k == 0) ? 8 : 2;
            m_pend[k]  = ref_count(din[k], int'(min[k]));
            m_pmode[k] = int'(min[k]);
            acc_cyc[k] = cyc;
          end
        end else if (m_timer[k] > 0) begin
          m_timer[k]--;
          if (m_timer[k] == 0) begin
            m_valid[k] = 1'b1;
            m_res[k]   = m_pend[k];
            m_mode[k]  = m_pmode[k];
          end
        end else if (m_valid[k] && rout[k]) begin
          m_valid[k] = 1'b0;
          m_ready[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("ready_in", k, rdy[k], m_ready[k]);
      chk("valid_out", k, vout[k], m_valid[k]);
      chk("out_state", k, ost[k], m_ready[k] ? 0 : (m_valid[k] ? 2 : 1));
      if (m_valid[k]) begin
        chk("data_out", k, dout[k], m_res[k]);
        chk("mode_out", k, mout[k], m_mode[k]);
      end
      if (reset && vout[k] && rout[k]) dut_xfers[k]++;
    end
  end

  task automatic send(int k, logic [7:0] d, logic [1:0] m, bit keep);
    int n = 0;
    vin[k] = 1'b1;
    din[k] = d;
    min[k] = m;
    while (!rdy[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", k, 0, 1);
    @(posedge clk); #1;
    if (!keep) vin[k] = 1'b0;
    din[k] = ~d;
    min[k] = m + 2'd1;
  endtask

  task automatic expect_res(int k, int exp, int em, int lat);
    int n = 0;
    while (!vout[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!vout[k]) chk("result_timeout", k, 0, 1);
    chk("lit_data", k, dout[k], exp);
    chk("lit_mode", k, mout[k], em);
    chk("latency", k, cyc - acc_cyc[k], lat);
  endtask

  int a0, a1, x0;
  logic [7:0] lzc_words [3] = '{8'h10, 8'h00, 8'h80};
  int         lzc_exp   [3] = '{3, 8, 0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      vin[k] = 1'b0; din[k] = 8'h00; min[k] = 2'd0; rout[k] = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready_in", k, rdy[k], 1);
      chk("rst_valid_out", k, vout[k], 0);
      chk("rst_data_out", k, dout[k], 0);
      chk("rst_mode_out", k, mout[k], 0);
      chk("rst_out_state", k, ost[k], 0);
    end
    @(posedge clk); #1 reset = 1'b1;

    send(0, 8'hFF, 2'd0, 0);
    expect_res(0, 8, 0, 8);
    @(negedge clk);
    chk("ready_after_xfer", 0, rdy[0], 1);

    send(0, 8'b1010_1011, 2'd2, 0);
    expect_res(0, 4, 2, 8);
    send(0, 8'h00, 2'd2, 0);
    expect_res(0, 7, 2, 8);

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 3; w++) begin
        send(k, lzc_words[w], 2'd3, 0);
        expect_res(k, lzc_exp[w], 3, (k == 0) ? 8 : 2);
      end
    end

    rout[0] = 1'b0;
    send(0, 8'h0F, 2'd1, 0);
    expect_res(0, 4, 1, 8);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vin[0] = (i % 2 == 0);
      din[0] = 8'hFF;
      min[0] = 2'd0;
      @(negedge clk);
      chk("stall_valid", 0, vout[0], 1);
      chk("stall_data", 0, dout[0], 4);
      chk("stall_ready_in", 0, rdy[0], 0);
    end
    @(posedge clk); #1;
    vin[0] = 1'b0;
    x0 = dut_xfers[0];
    rout[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall_one_xfer", 0, dut_xfers[0] - x0, 1);

    send(0, 8'hAA, 2'd0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_ready_in", 0, rdy[0], 1);
    chk("midrst_valid_out", 0, vout[0], 0);
    chk("midrst_out_state", 0, ost[0], 0);
    chk("midrst_data_out", 0, dout[0], 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send(0, 8'h01, 2'd0, 0);
    expect_res(0, 1, 0, 8);

    send(0, 8'h01, 2'd0, 1);
    a0 = acc_cyc[0];
    expect_res(0, 1, 0, 8);
    send(0, 8'h03, 2'd0, 1);
    a1 = acc_cyc[0];
    chk("b2b_spacing1", 0, a1 - a0, 10);
    expect_res(0, 2, 0, 8);
    send(0, 8'h07, 2'd0, 0);
    chk("b2b_spacing2", 0, acc_cyc[0] - a1, 10);
    expect_res(0, 3, 0, 8);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
